// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave for all CPOL/CPHA modes, oversampled and fully synchronous to clk.
// Latency: rx_valid rises SYNC_STAGES+2 clk after the sck pin edge that completes a word.
// Backpressure: TX words are taken only at word boundaries (TX_FILL + tx_underrun when none is offered);
//    a word completing into full RX storage is dropped with an rx_overrun pulse.
//
// Ports:
//    clk, rst              system clock (>= 4x sck), asynchronous active-high reset
//    spi_sck/cs/mosi       raw SPI pins from the master (asynchronous to clk)
//    spi_miso, spi_miso_oe slave-out data (TX shift register MSB) and its tristate enable
//    tx_data/valid/ready   next word to transmit; tx_ready pulses in the cycle the word is taken
//    rx_data/first/valid/ready  received words; rx_first marks the first word after CS assertion
//    tx_underrun, rx_overrun    single-cycle event pulses
//    busy                  high while selected
//
// Build option: define SPIS_RXFIFO_EN to store received words in an RX_DEPTH-entry FIFO;
//    otherwise a single holding register is used and RX_DEPTH is ignored.
module spi_slave_sync #(
   parameter int                WORD_W      = 8,
   parameter int                CPOL        = 0,
   parameter int                CPHA        = 0,
   parameter int                CS_ACTIVE   = 1,
   parameter int                SYNC_STAGES = 2,
   parameter logic [WORD_W-1:0] TX_FILL     = '0,
   parameter int                RX_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_first,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              tx_underrun,
   output logic              rx_overrun,
   output logic              busy
);
   localparam int            CW       = $clog2(WORD_W);
   localparam logic          SCK_IDLE = (CPOL != 0);
   localparam logic          CS_ON    = (CS_ACTIVE != 0);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

   // ---------------- pin synchronisers ----------------
   // The CS chain resets to "selected" and sel_prev to 1: a CS held asserted across
   // reset never looks like a fresh assertion, so a transfer only starts after the
   // master deselects and reselects.
   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
         cs_sync   <= {SYNC_STAGES{CS_ON}};
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   logic sck_s, mosi_s, sel;
   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign sel    = (cs_sync[SYNC_STAGES-1] == CS_ON);

   // ---------------- edge detection ----------------
   // Detected edges are registered; the datapath acts on them one cycle later,
   // together with the mosi value captured in the detection cycle.
   logic sck_prev, sel_prev, lead_q, trail_q, mosi_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_prev <= SCK_IDLE;
         sel_prev <= 1'b1;
         lead_q   <= 1'b0;
         trail_q  <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         sck_prev <= sck_s;
         sel_prev <= sel;
         lead_q   <= sel && (sck_s != sck_prev) && (sck_s != SCK_IDLE);
         trail_q  <= sel && (sck_s != sck_prev) && (sck_s == SCK_IDLE);
         mosi_q   <= mosi_s;
      end
   end

   // ---------------- transfer datapath ----------------
   logic              active, first_pending, skip_shift;
   logic [CW-1:0]     bit_cnt;
   logic [WORD_W-1:0] tx_sr, rx_sr;
   logic              samp, shft, rise, complete, load;
   logic [WORD_W-1:0] tx_word, rx_word;

   assign samp     = (CPHA != 0) ? trail_q : lead_q;
   assign shft     = (CPHA != 0) ? lead_q  : trail_q;
   assign rise     = sel && !sel_prev;
   assign complete = active && sel && samp && (bit_cnt == LAST_BIT);
   assign load     = rise || complete;
   assign tx_word  = tx_valid ? tx_data : TX_FILL;
   assign rx_word  = {rx_sr[WORD_W-2:0], mosi_q};

   assign tx_ready    = load && tx_valid;
   assign tx_underrun = load && !tx_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active        <= 1'b0;
         first_pending <= 1'b0;
         skip_shift    <= 1'b0;
         bit_cnt       <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
      end else if (!sel) begin
         // Deselected: drop any partial word and the pending TX word.
         active        <= 1'b0;
         first_pending <= 1'b0;
         skip_shift    <= 1'b0;
         bit_cnt       <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
      end else if (rise) begin
         active        <= 1'b1;
         first_pending <= 1'b1;
         bit_cnt       <= '0;
         rx_sr         <= '0;
         tx_sr         <= tx_word;
         // With CPHA=0 the master samples bit 0 before any shift edge, so the first
         // trailing edge after CS already belongs to bit 1 and must shift. With CPHA=1
         // the leading edge precedes the bit-0 sample and has to be swallowed.
         skip_shift    <= (CPHA != 0);
      end else if (active) begin
         if (samp) begin
            rx_sr <= rx_word;
            if (complete) begin
               bit_cnt       <= '0;
               first_pending <= 1'b0;
               tx_sr         <= tx_word;
               // The next shift edge still belongs to the finished word; hold the new MSB.
               skip_shift    <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else if (shft) begin
            if (skip_shift)
               skip_shift <= 1'b0;
            else
               tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
         end
      end
   end

   assign spi_miso    = tx_sr[WORD_W-1];
   assign spi_miso_oe = active;
   assign busy        = active;

   // ---------------- RX storage ----------------
   // A pop and a push in the same cycle on full storage both succeed.
   logic full, pop, push_ok;

`ifdef SPIS_RXFIFO_EN
   localparam int AW = $clog2(RX_DEPTH);

   logic [WORD_W:0] mem [RX_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;

   assign full    = (count == (AW+1)'(RX_DEPTH));
   assign pop     = (count != '0) && rx_ready;
   assign push_ok = complete && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {first_pending, rx_word};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
      end
   end

   assign rx_data  = mem[rd_ptr][WORD_W-1:0];
   assign rx_first = mem[rd_ptr][WORD_W];
   assign rx_valid = (count != '0);
`else
   localparam int unused_rx_depth = RX_DEPTH;

   logic [WORD_W-1:0] hold_dat;
   logic              hold_first, hold_vld;

   assign full    = hold_vld;
   assign pop     = hold_vld && rx_ready;
   assign push_ok = complete && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_dat   <= '0;
         hold_first <= 1'b0;
         hold_vld   <= 1'b0;
      end else if (push_ok) begin
         hold_dat   <= rx_word;
         hold_first <= first_pending;
         hold_vld   <= 1'b1;
      end else if (pop) begin
         hold_vld   <= 1'b0;
      end
   end

   assign rx_data  = hold_dat;
   assign rx_first = hold_first;
   assign rx_valid = hold_vld;
`endif

   assign rx_overrun = complete && full && !pop;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI master transfers into two slaves (mode 0 / CS high, mode 3 / CS low).
// Expected RX words are queued at stimulus time and popped by a monitor on every rx handshake;
// event pulses are counted by the monitor and compared against hand-computed totals.
module tb_spi_slave_sync;
   localparam int H = 8;   // sck half period in clk cycles
`ifdef SPIS_RXFIFO_EN
   localparam int NW = 5;  // words sent with rx_ready low
   localparam int NS = 4;  // words expected to be stored
`else
   localparam int NW = 2;
   localparam int NS = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       sck_a = 1'b0, cs_a = 1'b0, sck_b = 1'b1, cs_b = 1'b1, mosi = 1'b0;
   logic [7:0] tx_data_a = '0, tx_data_b = '0;
   logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0, rx_ready_a = 1'b1, rx_ready_b = 1'b1;
   logic       miso_a, miso_oe_a, tx_ready_a, rx_first_a, rx_valid_a, tx_underrun_a, rx_overrun_a, busy_a;
   logic       miso_b, miso_oe_b, tx_ready_b, rx_first_b, rx_valid_b, tx_underrun_b, rx_overrun_b, busy_b;
   logic [7:0] rx_data_a, rx_data_b;

   int checks = 0, failures = 0;
   int n_ready_a = 0, n_under_a = 0, n_over_a = 0, popped_a = 0;
   int n_ready_b = 0, n_under_b = 0, n_over_b = 0, popped_b = 0;
   int exp_ready_a = 0, exp_under_a = 0, exp_over_a = 0;
   logic [7:0] txq_a[$], txq_b[$];
   logic [8:0] rxq_a[$], rxq_b[$];
   logic [8:0] e_a, e_b;

   spi_slave_sync #(.WORD_W(8), .CPOL(0), .CPHA(0), .CS_ACTIVE(1), .SYNC_STAGES(2),
                    .TX_FILL(8'hFF), .RX_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .spi_sck(sck_a), .spi_cs(cs_a), .spi_mosi(mosi),
      .spi_miso(miso_a), .spi_miso_oe(miso_oe_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_first(rx_first_a), .rx_valid(rx_valid_a),
      .rx_ready(rx_ready_a), .tx_underrun(tx_underrun_a), .rx_overrun(rx_overrun_a), .busy(busy_a));

   spi_slave_sync #(.WORD_W(8), .CPOL(1), .CPHA(1), .CS_ACTIVE(0), .SYNC_STAGES(3),
                    .TX_FILL(8'h00), .RX_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .spi_sck(sck_b), .spi_cs(cs_b), .spi_mosi(mosi),
      .spi_miso(miso_b), .spi_miso_oe(miso_oe_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_first(rx_first_b), .rx_valid(rx_valid_b),
      .rx_ready(rx_ready_b), .tx_underrun(tx_underrun_b), .rx_overrun(rx_overrun_b), .busy(busy_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: counts event pulses and checks every RX handshake against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_ready_a)    n_ready_a++;
         if (tx_underrun_a) n_under_a++;
         if (rx_overrun_a)  n_over_a++;
         if (tx_ready_b)    n_ready_b++;
         if (tx_underrun_b) n_under_b++;
         if (rx_overrun_b)  n_over_b++;
         if (rx_valid_a && rx_ready_a) begin
            if (rxq_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL rx_a_unexpected: got %h first=%b, nothing expected", rx_data_a, rx_first_a);
            end else begin
               e_a = rxq_a.pop_front();
               chk("rx_a_data", rx_data_a, e_a[7:0]);
               chk("rx_a_first", rx_first_a, e_a[8]);
            end
         end
         if (rx_valid_b && rx_ready_b) begin
            if (rxq_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL rx_b_unexpected: got %h first=%b, nothing expected", rx_data_b, rx_first_b);
            end else begin
               e_b = rxq_b.pop_front();
               chk("rx_b_data", rx_data_b, e_b[7:0]);
               chk("rx_b_first", rx_first_b, e_b[8]);
            end
         end
      end
   end

   // TX sources: offer the head of each queue, retire it after a tx_ready pulse.
   always @(posedge clk) begin
      #1;
      while (popped_a < n_ready_a) begin void'(txq_a.pop_front()); popped_a++; end
      while (popped_b < n_ready_b) begin void'(txq_b.pop_front()); popped_b++; end
      tx_valid_a = (txq_a.size() != 0);
      tx_data_a  = tx_valid_a ? txq_a[0] : 8'h00;
      tx_valid_b = (txq_b.size() != 0);
      tx_data_b  = tx_valid_b ? txq_b[0] : 8'h00;
   end

   task automatic cs_on(input bit b);
      if (b) cs_b = 1'b0; else cs_a = 1'b1;
      repeat (2*H) @(posedge clk);
      #2;
   endtask

   task automatic cs_off(input bit b);
      if (!b) sck_a = 1'b0;
      repeat (H) @(posedge clk);
      #2;
      if (b) cs_b = 1'b1; else cs_a = 1'b0;
      repeat (2*H) @(posedge clk);
      #2;
   endtask

   // Both slaves sample on the rising sck edge (mode 0 and mode 3); the master does too.
   task automatic spi_word(input bit b, input int nbits, input logic [7:0] mo, input logic [7:0] exp_mi);
      logic [7:0] mi;
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         if (b) sck_b = 1'b0; else sck_a = 1'b0;
         mosi = mo[7-i];
         repeat (H) @(posedge clk);
         #2;
         if (b) sck_b = 1'b1; else sck_a = 1'b1;
         mi[7-i] = b ? miso_b : miso_a;
         repeat (H) @(posedge clk);
         #2;
      end
      if (nbits == 8) chk(b ? "miso_b_word" : "miso_a_word", {24'h0, mi}, {24'h0, exp_mi});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outs_a", {miso_a, miso_oe_a, tx_ready_a, rx_first_a, rx_valid_a,
                           tx_underrun_a, rx_overrun_a, busy_a, rx_data_a}, 0);
      chk("reset_outs_b", {miso_b, miso_oe_b, tx_ready_b, rx_first_b, rx_valid_b,
                           tx_underrun_b, rx_overrun_b, busy_b, rx_data_b}, 0);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;

      // 1: mode 0, A5 out, 3C in
      txq_a.push_back(8'hA5);
      rxq_a.push_back({1'b1, 8'h3C});
      cs_on(0);
      chk("t1_busy", busy_a, 1);
      chk("t1_oe", miso_oe_a, 1);
      spi_word(0, 8, 8'h3C, 8'hA5);
      cs_off(0);
      exp_ready_a += 1; exp_under_a += 1;
      chk("t1_ready_cnt", n_ready_a, exp_ready_a);
      chk("t1_under_cnt", n_under_a, exp_under_a);
      chk("t1_rx_left", rxq_a.size(), 0);

      // 2: mode 3 burst, CS active low
      txq_b.push_back(8'hC1); txq_b.push_back(8'hC2); txq_b.push_back(8'hC3);
      rxq_b.push_back({1'b1, 8'h11}); rxq_b.push_back({1'b0, 8'h22}); rxq_b.push_back({1'b0, 8'h33});
      cs_on(1);
      spi_word(1, 8, 8'h11, 8'hC1);
      spi_word(1, 8, 8'h22, 8'hC2);
      spi_word(1, 8, 8'h33, 8'hC3);
      cs_off(1);
      chk("t2_ready_cnt", n_ready_b, 3);
      chk("t2_under_cnt", n_under_b, 1);
      chk("t2_over_cnt", n_over_b, 0);
      chk("t2_rx_left", rxq_b.size(), 0);
      chk("t2_oe_idle", miso_oe_b, 0);

      // 3: nothing offered, TX_FILL goes out
      rxq_a.push_back({1'b1, 8'h81}); rxq_a.push_back({1'b0, 8'h7E});
      cs_on(0);
      spi_word(0, 8, 8'h81, 8'hFF);
      spi_word(0, 8, 8'h7E, 8'hFF);
      cs_off(0);
      exp_under_a += 3;
      chk("t3_under_cnt", n_under_a, exp_under_a);
      chk("t3_ready_cnt", n_ready_a, exp_ready_a);

      // 4: consumer stalled -> storage fills, last word overruns
      rx_ready_a = 1'b0;
      cs_on(0);
      for (int w = 0; w < NW; w++) begin
         spi_word(0, 8, 8'(w + 1), 8'hFF);
         if (w < NS) rxq_a.push_back({(w == 0), 8'(w + 1)});
      end
      cs_off(0);
      exp_under_a += NW + 1; exp_over_a += 1;
      chk("t4_over_cnt", n_over_a, exp_over_a);
      chk("t4_held_valid", rx_valid_a, 1);
      chk("t4_head_data", rx_data_a, 8'h01);
      chk("t4_head_first", rx_first_a, 1);
      rx_ready_a = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("t4_rx_left", rxq_a.size(), 0);
      chk("t4_drained", rx_valid_a, 0);

      // 5: deselect after 5 bits, then a clean word
      cs_on(0);
      spi_word(0, 5, 8'hFF, 8'h00);
      cs_off(0);
      exp_under_a += 1;
      chk("t5_busy_off", busy_a, 0);
      chk("t5_oe_off", miso_oe_a, 0);
      chk("t5_no_push", rx_valid_a, 0);
      rxq_a.push_back({1'b1, 8'h5A});
      cs_on(0);
      spi_word(0, 8, 8'h5A, 8'hFF);
      cs_off(0);
      exp_under_a += 2;
      chk("t5_under_cnt", n_under_a, exp_under_a);
      chk("t5_rx_left", rxq_a.size(), 0);

      // 6: reset mid-word, then a full transaction after reselection
      cs_on(0);
      exp_under_a += 1;
      spi_word(0, 4, 8'hF0, 8'h00);
      rst = 1'b1;
      #1;
      chk("t6_rst_outs", {miso_a, miso_oe_a, tx_ready_a, rx_first_a, rx_valid_a,
                          tx_underrun_a, rx_overrun_a, busy_a, rx_data_a}, 0);
      cs_a = 1'b0; sck_a = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      txq_a.push_back(8'h96);
      rxq_a.push_back({1'b1, 8'h69});
      cs_on(0);
      spi_word(0, 8, 8'h69, 8'h96);
      cs_off(0);
      exp_ready_a += 1; exp_under_a += 1;
      chk("t6_ready_cnt", n_ready_a, exp_ready_a);
      chk("t6_under_cnt", n_under_a, exp_under_a);
      chk("t6_over_cnt", n_over_a, exp_over_a);

      repeat (10) @(posedge clk);
      #2;
      chk("end_rxq_a", rxq_a.size(), 0);
      chk("end_rxq_b", rxq_b.size(), 0);
      chk("end_txq_a", txq_a.size(), 0);
      chk("end_txq_b", txq_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal;
   end
endmodule
